// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] INSN_NOP    = 32'h0000_0013;

    // One fetched word together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction memory read port, redirect input and
// the decode-side valid/ready output. master = fetch unit, slave = environment.
interface instruction_fetch_if;
    import ifetch_pkg::*;

    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_instruction;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instruction;
    logic [XLEN-1:0] out_pc;
    logic            halted;

    modport master (
        output mem_address,
        input  mem_instruction,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc,
        output halted
    );

    modport slave (
        input  mem_address,
        output mem_instruction,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries. Flush wins over push/pop; a push is
// accepted while full only when a pop frees the head in the same cycle.
// Head is read combinationally and forced to zero when the queue is empty.
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         valid,
    output logic         full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    fetch_entry_t  storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until counted valid, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

    assign head = valid ? storage[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, enqueue/redirect control and an
// optional halt-on-EBREAK (enabled by defining IFETCH_HALT_EN).
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    instruction_fetch_if.master   bus
);

    logic [XLEN-1:0] pc;
    logic            halt_q;
    logic            q_full;
    logic            q_valid;
    logic            enq;
    logic            deq;
    fetch_entry_t    q_head;
    fetch_entry_t    push_data;
    logic            unused_tgt_lsb;

    // Redirect kills any enqueue; a full queue only takes a word if decode drains it.
    assign deq       = q_valid && bus.out_ready;
    assign enq       = !bus.redirect_valid && !halt_q && (!q_full || deq);
    assign push_data = '{pc: pc, instruction: bus.mem_instruction};

    fetch_queue #(
        .DEPTH     (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (enq),
        .push_data (push_data),
        .pop       (deq),
        .head      (q_head),
        .valid     (q_valid),
        .full      (q_full)
    );

    // PC: redirect reloads a word-aligned target, otherwise advance per fetched word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_target[XLEN-1:2], 2'b00};
        end else if (enq) begin
            pc <= pc + 32'd4;
        end
    end

`ifdef IFETCH_HALT_EN
    // Halt after enqueuing an EBREAK; only a redirect (or reset) restarts fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            halt_q <= 1'b0;
        end else if (enq && (bus.mem_instruction == INSN_EBREAK)) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign halt_q = 1'b0;
`endif

    assign unused_tgt_lsb      = ^bus.redirect_target[1:0];

    assign bus.mem_address     = pc;
    assign bus.out_valid       = q_valid;
    assign bus.out_pc          = q_head.pc;
    assign bus.out_instruction = q_head.instruction;
    assign bus.halted          = halt_q;

endmodule
